vc_assignment: RTL and testbench
================================

Name: vc_assignment

Overview:
- Per-output-port stage directly downstream of the global switch allocator.
- Takes the winning input port/VC granted by the global allocator and assigns it a free downstream (output) VC.
- Tracks per-output-VC credits returned from the next router, and registers the result into the switch-traversal (ST) pipeline stage.
- Feeds `vc_assignment_vld_o` back to the global allocator's round-robin update.

Parameters:
- INPUT_NUM, 4, number of input ports competing for this output port.
- OUT_VC_NUM, 4, number of VCs on the downstream link; must be ≤ 2^VC_ID_NUM_MAX_W.
- VC_DEPTH, 2, buffer slots per downstream VC, equal to the initial credits per VC.
- CREDIT_W, VC_DEPTH+1 > 1 ? $clog2(VC_DEPTH+1) : 1, credit counter width.
- VC_ID_NUM_MAX_W is the package constant, not a parameter.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- sa_global_vld_i  in  1  global allocator has a winner.
- sa_global_inport_id_oh_i  in  INPUT_NUM  one-hot winning input port.
- sa_global_inport_vc_id_i  in  VC_ID_NUM_MAX_W  winning input VC.
- rx_lcrd_vld_i  in  1  credit return from downstream router.
- rx_lcrd_id_i  in  VC_ID_NUM_MAX_W  VC of the returned credit.
- vc_assignment_vld_o  out  1  allocation made this cycle (combinational); drives rr update and input-buffer pop.
- vc_assignment_vc_id_o  out  VC_ID_NUM_MAX_W  assigned output VC (combinational).
- st_vld_o  out  1  registered ST-stage valid.
- st_inport_id_oh_o  out  INPUT_NUM  registered input port.
- st_inport_vc_id_o  out  VC_ID_NUM_MAX_W  registered input VC.
- st_outport_vc_id_o  out  VC_ID_NUM_MAX_W  registered output VC.
- credit_cnt_o  out  OUT_VC_NUM*CREDIT_W  current credit counters.
- credit_err_o  out  1  sticky error: credit overflow or bad VC id.

Behaviour:
- Reset (rstn=0 at posedge):
  - credit[v] = VC_DEPTH for all v.
  - rr pointer = 0.
  - st_vld_o = 0; all st_* payload = 0.
  - credit_err_o = 0.
  - Combinational outputs follow the reset state: vc_assignment_vld_o = sa_global_vld_i, since all VCs are free.
- Free mask: free[v] = (credit[v] != 0).
- Selection:
  - Rotating priority over free[], starting at the pointer: lowest index v ≥ ptr that is free; if none, wrap to the lowest free v < ptr.
  - vc_assignment_vld_o = sa_global_vld_i & |free.
  - vc_assignment_vc_id_o = selected v, zero-extended; 0 when not valid.
- Credit update each cycle, per v:
  - credit[v] <= credit[v] − dec + inc.
  - dec = vc_assignment_vld_o & (sel == v).
  - inc = rx_lcrd_vld_i & (rx_lcrd_id_i == v).
  - Simultaneous dec and inc on the same VC: net unchanged.
  - A return to a VC at 0 credits in the same cycle cannot allocate it; free[] uses the current register value.
- Overflow: inc while credit[v] == VC_DEPTH and no dec on v → credit stays VC_DEPTH, credit_err_o set.
- Bad id: rx_lcrd_id_i ≥ OUT_VC_NUM with rx_lcrd_vld_i → ignored, credit_err_o set.
- credit_err_o stays set until reset.
- Pointer: on vc_assignment_vld_o, ptr <= (sel == OUT_VC_NUM−1) ? 0 : sel+1. Otherwise ptr holds.
- ST register, 1-cycle latency:
  - st_vld_o <= vc_assignment_vld_o.
  - On allocation, payload <= {sa_global_inport_id_oh_i, sa_global_inport_vc_id_i, sel}.
  - When not allocating, payload holds its old value; consumers qualify with st_vld_o.
- No backpressure: the ST stage always accepts. Back-to-back allocations every cycle are supported.
- All credits zero with sa_global_vld_i=1 → vc_assignment_vld_o = 0. Pointer and ST stage get no update, and the global allocator's rr does not advance.
- Reset asserted mid-operation: in-flight ST entry dropped (st_vld_o = 0 next cycle), credits restored to full. The downstream router is reset together with this block.

Test Plan:
- Reset, then sa_global_vld_i=1, inport_oh=4'b0010, in-vc=1 → vc_assignment_vld_o=1 and vc_id=0 in the same cycle; next cycle st_vld_o=1, st_inport_id_oh_o=4'b0010, st_inport_vc_id_o=1, st_outport_vc_id_o=0; credit[0]=1.
- 8 consecutive grants, no returns (OUT_VC_NUM=4, VC_DEPTH=2) → assigned VCs 0,1,2,3,0,1,2,3; 9th cycle vc_assignment_vld_o=0, all credits 0, st_vld_o=0 the following cycle.
- From the all-zero state, return a credit on VC 2 → next cycle a grant is assigned VC 2; credit[2] returns to 0.
- credit[1]=1 with pointer=1, simultaneous grant and return on VC 1 → assigned VC 1, credit[1] stays 1, pointer becomes 2.
- Return on VC 3 while credit[3]=2 → credit[3] stays 2, credit_err_o=1 and remains 1 until rstn=0.
- After 3 allocations, assert rstn=0 for one cycle with sa_global_vld_i=1 → st_vld_o=0 after the reset edge, all credits=2, pointer=0, credit_err_o=0.

Source files
------------

// File: rtl/vc_assignment.sv
// Output-VC assignment stage for one output port: picks a free downstream VC
// for the switch-allocator winner, tracks downstream credits, and registers the ST stage.
package vc_assignment_pkg;
  localparam int VC_ID_NUM_MAX_W = 3;
endpackage

module vc_assignment
  import vc_assignment_pkg::*;
#(
  parameter int INPUT_NUM  = 4,
  parameter int OUT_VC_NUM = 4,
  parameter int VC_DEPTH   = 2,
  parameter int CREDIT_W   = (VC_DEPTH + 1 > 1) ? $clog2(VC_DEPTH + 1) : 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               sa_global_vld_i,
  input  logic [INPUT_NUM-1:0]               sa_global_inport_id_oh_i,
  input  logic [VC_ID_NUM_MAX_W-1:0]         sa_global_inport_vc_id_i,
  input  logic                               rx_lcrd_vld_i,
  input  logic [VC_ID_NUM_MAX_W-1:0]         rx_lcrd_id_i,
  output logic                               vc_assignment_vld_o,
  output logic [VC_ID_NUM_MAX_W-1:0]         vc_assignment_vc_id_o,
  output logic                               st_vld_o,
  output logic [INPUT_NUM-1:0]               st_inport_id_oh_o,
  output logic [VC_ID_NUM_MAX_W-1:0]         st_inport_vc_id_o,
  output logic [VC_ID_NUM_MAX_W-1:0]         st_outport_vc_id_o,
  output logic [OUT_VC_NUM*CREDIT_W-1:0]     credit_cnt_o,
  output logic                               credit_err_o
);

  localparam int PTR_W = (OUT_VC_NUM > 1) ? $clog2(OUT_VC_NUM) : 1;
  localparam logic [CREDIT_W-1:0]        CREDIT_FULL = CREDIT_W'(VC_DEPTH);
  localparam logic [VC_ID_NUM_MAX_W:0]   ID_LIMIT    = (VC_ID_NUM_MAX_W + 1)'(OUT_VC_NUM);
  localparam logic [PTR_W-1:0]           PTR_LAST    = PTR_W'(OUT_VC_NUM - 1);

  typedef logic [OUT_VC_NUM-1:0] vc_mask_t;

  // Lowest set bit of a VC mask; 0 when the mask is empty.
  function automatic logic [PTR_W-1:0] lowest_set(input vc_mask_t m);
    lowest_set = '0;
    for (int v = OUT_VC_NUM - 1; v >= 0; v--) begin
      if (m[v]) lowest_set = PTR_W'(v);
    end
  endfunction

  logic [OUT_VC_NUM-1:0][CREDIT_W-1:0] credit_q, credit_d;
  logic [PTR_W-1:0]                    ptr_q, ptr_d;
  logic                                err_q, err_d;
  logic                                st_vld_q, st_vld_d;
  logic [INPUT_NUM-1:0]                st_oh_q, st_oh_d;
  logic [VC_ID_NUM_MAX_W-1:0]          st_in_vc_q, st_in_vc_d;
  logic [VC_ID_NUM_MAX_W-1:0]          st_out_vc_q, st_out_vc_d;

  vc_mask_t         free_mask;
  vc_mask_t         upper_mask;
  vc_mask_t         dec_vec;
  vc_mask_t         inc_vec;
  logic [PTR_W-1:0] sel;
  logic             alloc;
  logic             id_ok;

  // Rotating-priority pick: first free VC at or above the pointer, else wrap.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_mask  = '0;
    upper_mask = '0;
    for (int v = 0; v < OUT_VC_NUM; v++) begin
      free_mask[v]  = (credit_q[v] != '0);
      upper_mask[v] = free_mask[v] && (PTR_W'(v) >= ptr_q);
    end
    sel   = (|upper_mask) ? lowest_set(upper_mask) : lowest_set(free_mask);
    alloc = sa_global_vld_i && (|free_mask);
  end

  assign vc_assignment_vld_o   = alloc;
  assign vc_assignment_vc_id_o = alloc ? VC_ID_NUM_MAX_W'(sel) : '0;

  // A credit returned to an empty VC only becomes usable next cycle.
  always_comb begin
    id_ok    = ({1'b0, rx_lcrd_id_i} < ID_LIMIT);
    dec_vec  = '0;
    inc_vec  = '0;
    credit_d = credit_q;
    err_d    = err_q | (rx_lcrd_vld_i & ~id_ok);
    for (int v = 0; v < OUT_VC_NUM; v++) begin
      dec_vec[v] = alloc && (sel == PTR_W'(v));
      inc_vec[v] = rx_lcrd_vld_i && id_ok && (rx_lcrd_id_i == VC_ID_NUM_MAX_W'(v));
      if (inc_vec[v] && !dec_vec[v]) begin
        if (credit_q[v] == CREDIT_FULL) begin
          err_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CREDIT_W'(1);
        end
      end else if (dec_vec[v] && !inc_vec[v]) begin
        credit_d[v] = credit_q[v] - CREDIT_W'(1);
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    st_vld_d    = alloc;
    st_oh_d     = st_oh_q;
    st_in_vc_d  = st_in_vc_q;
    st_out_vc_d = st_out_vc_q;
    if (alloc) begin
      ptr_d       = (sel == PTR_LAST) ? '0 : PTR_W'(sel + PTR_W'(1));
      st_oh_d     = sa_global_inport_id_oh_i;
      st_in_vc_d  = sa_global_inport_vc_id_i;
      st_out_vc_d = VC_ID_NUM_MAX_W'(sel);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int v = 0; v < OUT_VC_NUM; v++) credit_q[v] <= CREDIT_FULL;
      ptr_q       <= '0;
      err_q       <= 1'b0;
      st_vld_q    <= 1'b0;
      st_oh_q     <= '0;
      st_in_vc_q  <= '0;
      st_out_vc_q <= '0;
    end else begin
      credit_q    <= credit_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      st_vld_q    <= st_vld_d;
      st_oh_q     <= st_oh_d;
      st_in_vc_q  <= st_in_vc_d;
      st_out_vc_q <= st_out_vc_d;
    end
  end

  assign st_vld_o           = st_vld_q;
  assign st_inport_id_oh_o  = st_oh_q;
  assign st_inport_vc_id_o  = st_in_vc_q;
  assign st_outport_vc_id_o = st_out_vc_q;
  assign credit_cnt_o       = credit_q;
  assign credit_err_o       = err_q;

endmodule

// File: tb/tb_vc_assignment.sv
// Directed bench for vc_assignment: allocation order, credit tracking,
// overflow / bad-id error and reset behaviour, with hand-computed expectations.
module tb_vc_assignment;
  import vc_assignment_pkg::*;

  localparam int INPUT_NUM  = 4;
  localparam int OUT_VC_NUM = 4;
  localparam int VC_DEPTH   = 2;
  localparam int CREDIT_W   = 2;
  localparam int W          = VC_ID_NUM_MAX_W;

  logic                           clk;
  logic                           rstn;
  logic                           sa_vld;
  logic [INPUT_NUM-1:0]           sa_oh;
  logic [W-1:0]                   sa_vc;
  logic                           rx_vld;
  logic [W-1:0]                   rx_id;
  logic                           va_vld;
  logic [W-1:0]                   va_id;
  logic                           st_vld;
  logic [INPUT_NUM-1:0]           st_oh;
  logic [W-1:0]                   st_in_vc;
  logic [W-1:0]                   st_out_vc;
  logic [OUT_VC_NUM*CREDIT_W-1:0] credit_cnt;
  logic                           credit_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  vc_assignment #(
    .INPUT_NUM (INPUT_NUM),
    .OUT_VC_NUM(OUT_VC_NUM),
    .VC_DEPTH  (VC_DEPTH),
    .CREDIT_W  (CREDIT_W)
  ) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .sa_global_vld_i         (sa_vld),
    .sa_global_inport_id_oh_i(sa_oh),
    .sa_global_inport_vc_id_i(sa_vc),
    .rx_lcrd_vld_i           (rx_vld),
    .rx_lcrd_id_i            (rx_id),
    .vc_assignment_vld_o     (va_vld),
    .vc_assignment_vc_id_o   (va_id),
    .st_vld_o                (st_vld),
    .st_inport_id_oh_o       (st_oh),
    .st_inport_vc_id_o       (st_in_vc),
    .st_outport_vc_id_o      (st_out_vc),
    .credit_cnt_o            (credit_cnt),
    .credit_err_o            (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input logic v, input logic [INPUT_NUM-1:0] oh, input logic [W-1:0] vc);
    sa_vld = v;
    sa_oh  = oh;
    sa_vc  = vc;
  endtask

  task automatic ret(input logic v, input logic [W-1:0] id);
    rx_vld = v;
    rx_id  = id;
  endtask

  initial begin
    rstn = 1'b0;
    grant(1'b0, '0, '0);
    ret(1'b0, '0);
    tick();
    grant(1'b1, 4'b0001, 3'd0);
    tick();
    #1;
    check("rst_st_vld", st_vld, 0);
    check("rst_st_oh", st_oh, 0);
    check("rst_st_out", st_out_vc, 0);
    check("rst_credits", credit_cnt, 8'hAA);
    check("rst_err", credit_err, 0);
    check("rst_comb_vld", va_vld, 1);
    check("rst_comb_id", va_id, 0);

    // Single grant
    rstn = 1'b1;
    grant(1'b1, 4'b0010, 3'd1);
    #1;
    check("g1_vld", va_vld, 1);
    check("g1_id", va_id, 0);
    tick();
    grant(1'b0, '0, '0);
    check("g1_st_vld", st_vld, 1);
    check("g1_st_oh", st_oh, 4'b0010);
    check("g1_st_in", st_in_vc, 1);
    check("g1_st_out", st_out_vc, 0);
    check("g1_credits", credit_cnt, 8'hA9);
    #1;
    check("idle_vld", va_vld, 0);
    check("idle_id", va_id, 0);
    tick();
    check("idle_st_vld", st_vld, 0);

    // Re-reset, then drain all credits with 8 grants
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rerst_credits", credit_cnt, 8'hAA);
    for (int i = 0; i < 8; i++) begin
      grant(1'b1, 4'(1 << (i % 4)), 3'(i));
      #1;
      check("drain_vld", va_vld, 1);
      check("drain_id", va_id, 32'(i % 4));
      tick();
      check("drain_st_vld", st_vld, 1);
      check("drain_st_out", st_out_vc, 32'(i % 4));
      check("drain_st_oh", st_oh, 32'(1 << (i % 4)));
      check("drain_st_in", st_in_vc, 32'(i));
    end
    check("drain_credits", credit_cnt, 0);
    grant(1'b1, 4'b0100, 3'd5);
    #1;
    check("empty_vld", va_vld, 0);
    check("empty_id", va_id, 0);
    tick();
    check("empty_st_vld", st_vld, 0);
    check("empty_st_out_hold", st_out_vc, 3);
    check("empty_st_oh_hold", st_oh, 4'b1000);
    check("empty_st_in_hold", st_in_vc, 7);

    // Return on VC2 while granting: not usable this cycle
    ret(1'b1, 3'd2);
    #1;
    check("ret2_same_cycle_vld", va_vld, 0);
    tick();
    check("ret2_credits", credit_cnt, 8'h10);
    ret(1'b0, '0);
    grant(1'b1, 4'b0001, 3'd2);
    #1;
    check("ret2_grant_vld", va_vld, 1);
    check("ret2_grant_id", va_id, 2);
    tick();
    check("ret2_st_vld", st_vld, 1);
    check("ret2_st_out", st_out_vc, 2);
    check("ret2_credits_after", credit_cnt, 0);

    // Pointer now 3: refill VC1 and VC0, grant wraps to VC0
    grant(1'b0, '0, '0);
    ret(1'b1, 3'd1);
    tick();
    ret(1'b1, 3'd0);
    tick();
    check("refill_credits", credit_cnt, 8'h05);
    ret(1'b0, '0);
    grant(1'b1, 4'b1000, 3'd3);
    #1;
    check("wrap_id", va_id, 0);
    tick();
    check("wrap_credits", credit_cnt, 8'h04);
    // Pointer=1, credit[1]=1: simultaneous grant and return on VC1
    ret(1'b1, 3'd1);
    #1;
    check("simul_vld", va_vld, 1);
    check("simul_id", va_id, 1);
    tick();
    check("simul_credits", credit_cnt, 8'h04);
    // Pointer must be 2: with VC1 and VC3 free the pick is VC3
    grant(1'b0, '0, '0);
    ret(1'b1, 3'd3);
    tick();
    check("v3_credits", credit_cnt, 8'h44);
    ret(1'b0, '0);
    grant(1'b1, 4'b0100, 3'd4);
    #1;
    check("ptr2_id", va_id, 3);
    tick();
    check("ptr2_credits", credit_cnt, 8'h04);

    // Overflow on VC3
    grant(1'b0, '0, '0);
    ret(1'b1, 3'd3);
    tick();
    check("ovf_step1", credit_cnt, 8'h44);
    check("ovf_err1", credit_err, 0);
    tick();
    check("ovf_step2", credit_cnt, 8'h84);
    check("ovf_err2", credit_err, 0);
    tick();
    check("ovf_sat", credit_cnt, 8'h84);
    check("ovf_err", credit_err, 1);
    ret(1'b0, '0);
    tick();
    tick();
    check("ovf_err_sticky", credit_err, 1);

    // Reset mid-operation after 3 allocations
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("clr_err", credit_err, 0);
    check("clr_credits", credit_cnt, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      grant(1'b1, 4'b0001, 3'd0);
      tick();
    end
    check("pre_rst_credits", credit_cnt, 8'h95);
    check("pre_rst_st_vld", st_vld, 1);
    rstn = 1'b0;
    tick();
    check("mid_rst_st_vld", st_vld, 0);
    check("mid_rst_credits", credit_cnt, 8'hAA);
    check("mid_rst_err", credit_err, 0);
    rstn = 1'b1;
    grant(1'b1, 4'b0010, 3'd6);
    #1;
    check("post_rst_id", va_id, 0);
    tick();
    check("post_rst_st_vld", st_vld, 1);
    check("post_rst_st_in", st_in_vc, 6);
    check("post_rst_credits", credit_cnt, 8'hA9);

    // Bad credit id
    grant(1'b0, '0, '0);
    ret(1'b1, 3'd5);
    tick();
    ret(1'b0, '0);
    check("badid_credits", credit_cnt, 8'hA9);
    check("badid_err", credit_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
